// File: rtl/cdb_arbiter_if.sv
// Functional-unit result ports and CDB broadcast port of the CDB arbiter.
// slave is the arbiter side; master is the side that drives the units and CDB consumers.
interface cdb_arbiter_if #(
  parameter int N_FU              = 3,
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 4
);
  logic [N_FU-1:0]                   i_fu_valid;
  logic [N_FU-1:0]                   o_fu_ready;
  logic [N_FU*BW_TAG-1:0]            i_fu_tag_flatten;
  logic [N_FU*BW_PROCESSOR_DATA-1:0] i_fu_wdata_flatten;
  logic                              o_cdb_valid;
  logic                              i_cdb_ready;
  logic [BW_TAG-1:0]                 o_cdb_tag;
  logic signed [BW_PROCESSOR_DATA-1:0] o_cdb_wdata;
  logic [N_FU-1:0]                   o_cdb_src;

  modport slave (
    input  i_fu_valid, i_fu_tag_flatten, i_fu_wdata_flatten, i_cdb_ready,
    output o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata, o_cdb_src
  );

  modport master (
    output i_fu_valid, i_fu_tag_flatten, i_fu_wdata_flatten, i_cdb_ready,
    input  o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata, o_cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one functional unit per cycle onto the CDB.
// The winning result goes into a one-entry output stage that can drain and reload in the same cycle.
module cdb_arbiter #(
  parameter int N_FU              = 3,
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_TAG            = 4
) (
  input logic clk,
  input logic rst,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic                                cdb_valid_q, cdb_valid_d;
  logic [BW_TAG-1:0]                   cdb_tag_q, cdb_tag_d;
  logic signed [BW_PROCESSOR_DATA-1:0] cdb_wdata_q, cdb_wdata_d;
  logic [N_FU-1:0]                     cdb_src_q, cdb_src_d;
  logic [PTR_W-1:0]                    ptr_q, ptr_d;

  logic              load_en;
  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  logic [N_FU-1:0]   fu_ready;

  // Scan from the highest offset down so the nearest requester after ptr wins.
  always_comb begin
    load_en     = !cdb_valid_q || bus.i_cdb_ready;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = N_FU - 1; i >= 0; i--) begin
      int sum;
      sum = int'(ptr_q) + i;
      if (sum >= N_FU) sum = sum - N_FU;
      if (bus.i_fu_valid[sum]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(sum);
      end
    end
    fu_ready = '0;
    if (load_en && grant_found && !rst) fu_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_wdata_d = cdb_wdata_q;
    cdb_src_d   = cdb_src_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (grant_found) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = bus.i_fu_tag_flatten[int'(grant_idx)*BW_TAG +: BW_TAG];
        cdb_wdata_d = bus.i_fu_wdata_flatten[int'(grant_idx)*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
        cdb_src_d   = fu_ready;
        ptr_d       = (grant_idx == PTR_W'(N_FU - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_wdata_q <= '0;
      cdb_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_wdata_q <= cdb_wdata_d;
      cdb_src_q   <= cdb_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.o_fu_ready  = fu_ready;
  assign bus.o_cdb_valid = cdb_valid_q;
  assign bus.o_cdb_tag   = cdb_tag_q;
  assign bus.o_cdb_wdata = cdb_wdata_q;
  assign bus.o_cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with three functional units.
module tb_cdb_arbiter;
  localparam int N_FU = 3;
  localparam int BW_D = 32;
  localparam int BW_T = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cdb_arbiter_if #(.N_FU(N_FU), .BW_PROCESSOR_DATA(BW_D), .BW_TAG(BW_T)) bus ();

  cdb_arbiter #(.N_FU(N_FU), .BW_PROCESSOR_DATA(BW_D), .BW_TAG(BW_T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_unit(input int k, input logic [BW_T-1:0] tag, input logic [BW_D-1:0] data);
    bus.i_fu_tag_flatten[k*BW_T +: BW_T]     = tag;
    bus.i_fu_wdata_flatten[k*BW_D +: BW_D]   = data;
  endtask

  // Advance one rising edge, leaving us at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.i_fu_valid = '1;
    bus.i_cdb_ready = 1'b1;
    bus.i_fu_tag_flatten = '0;
    bus.i_fu_wdata_flatten = '0;

    // Reset / idle
    @(negedge clk);
    #1 chk("rst_ready", bus.o_fu_ready, 3'b000);
    bus.i_fu_valid = '0;
    step();
    rst = 1'b0;
    #1;
    chk("idle_valid", bus.o_cdb_valid, 1'b0);
    chk("idle_tag",   bus.o_cdb_tag, 4'd0);
    chk("idle_wdata", bus.o_cdb_wdata, 32'd0);
    chk("idle_src",   bus.o_cdb_src, 3'b000);
    chk("idle_ready", bus.o_fu_ready, 3'b000);
    step();
    chk("idle_valid2", bus.o_cdb_valid, 1'b0);

    // Single request from unit 1
    set_unit(1, 4'd5, -32'sd7);
    bus.i_fu_valid = 3'b010;
    #1 chk("single_ready", bus.o_fu_ready, 3'b010);
    step();
    bus.i_fu_valid = '0;
    #1;
    chk("single_valid", bus.o_cdb_valid, 1'b1);
    chk("single_tag",   bus.o_cdb_tag, 4'd5);
    chk("single_wdata", bus.o_cdb_wdata, -7);
    chk("single_src",   bus.o_cdb_src, 3'b010);
    step();
    chk("single_drain", bus.o_cdb_valid, 1'b0);
    chk("single_hold_tag", bus.o_cdb_tag, 4'd5);

    // Round-robin from ptr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_unit(0, 4'd1, 32'd100);
    set_unit(1, 4'd2, 32'd200);
    set_unit(2, 4'd3, 32'd300);
    bus.i_fu_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr_ready%0d", k), bus.o_fu_ready, 3'b001 << (k % 3));
      if (k > 0) begin
        chk($sformatf("rr_valid%0d", k), bus.o_cdb_valid, 1'b1);
        chk($sformatf("rr_tag%0d", k), bus.o_cdb_tag, 4'((k - 1) % 3 + 1));
      end
      step();
    end
    #1;
    chk("rr_tag_last", bus.o_cdb_tag, 4'd3);
    chk("rr_src_last", bus.o_cdb_src, 3'b100);

    // Backpressure with units 0 and 2 pending
    bus.i_fu_valid  = 3'b101;
    bus.i_cdb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_ready", bus.o_fu_ready, 3'b000);
      chk("bp_valid", bus.o_cdb_valid, 1'b1);
      chk("bp_tag",   bus.o_cdb_tag, 4'd3);
      chk("bp_wdata", bus.o_cdb_wdata, 32'd300);
      chk("bp_src",   bus.o_cdb_src, 3'b100);
      step();
    end
    bus.i_cdb_ready = 1'b1;
    #1 chk("bp_release_ready", bus.o_fu_ready, 3'b001);
    step();
    #1;
    chk("bp_reload_valid", bus.o_cdb_valid, 1'b1);
    chk("bp_reload_tag",   bus.o_cdb_tag, 4'd1);
    chk("bp_reload_wdata", bus.o_cdb_wdata, 32'd100);
    chk("bp_reload_src",   bus.o_cdb_src, 3'b001);
    chk("bp_next_ready",   bus.o_fu_ready, 3'b100);
    step();
    #1 chk("bp_next_tag", bus.o_cdb_tag, 4'd3);

    // Rotation after skip: ptr=0 -> grant unit0 -> ptr=1
    bus.i_fu_valid = 3'b001;
    #1 chk("skip_ready_a", bus.o_fu_ready, 3'b001);
    step();
    #1 chk("skip_ready_b", bus.o_fu_ready, 3'b001);
    step();
    bus.i_fu_valid = 3'b011;
    #1 chk("skip_ready_c", bus.o_fu_ready, 3'b010);
    step();
    bus.i_fu_valid = '0;
    #1 chk("skip_tag", bus.o_cdb_tag, 4'd2);

    // Reset mid-stall; ptr is 2 here so unit1 grant leaves ptr=2
    step();
    bus.i_fu_valid = 3'b010;
    set_unit(1, 4'd9, 32'hDEAD_BEEF);
    step();
    bus.i_fu_valid  = '0;
    bus.i_cdb_ready = 1'b0;
    #1 chk("mid_pending", bus.o_cdb_tag, 4'd9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_valid", bus.o_cdb_valid, 1'b0);
    chk("mid_tag",   bus.o_cdb_tag, 4'd0);
    chk("mid_wdata", bus.o_cdb_wdata, 32'd0);
    chk("mid_src",   bus.o_cdb_src, 3'b000);
    bus.i_cdb_ready = 1'b1;
    step();
    chk("mid_no_bcast", bus.o_cdb_valid, 1'b0);
    bus.i_fu_valid = 3'b110;
    #1 chk("mid_ptr0_ready", bus.o_fu_ready, 3'b010);
    bus.i_fu_valid = '0;

    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
